// File: rtl/led_step_sequencer.sv
// led_step_sequencer: button-triggered one-hot step sequencer with per-step dwell,
// single-shot or looping operation, and abort on a second button edge.
module led_step_sequencer #(
    parameter int NUM_CH  = 3,
    parameter int DWELL_W = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               button,
    input  logic               mode_loop,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_CH-1:0]  ch_out,
    output logic               busy,
    output logic               done
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, nxt_state;
    logic [IDX_W-1:0]   idx, nxt_idx;
    logic [DWELL_W-1:0] cnt, nxt_cnt, dwell_l, nxt_dwell;
    logic               button_d, rise, nxt_done;

    assign rise = button & ~button_d;

    // Abort outranks every other RUN transition, including the wrap point.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        nxt_dwell = dwell_l;
        nxt_done  = 1'b0;
        if (state == IDLE) begin
            if (rise) begin
                nxt_state = RUN;
                nxt_idx   = '0;
                nxt_cnt   = '0;
                nxt_dwell = dwell;
            end
        end else if (rise) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else if (cnt != dwell_l) begin
            nxt_cnt = cnt + 1'b1;
        end else begin
            nxt_cnt = '0;
            if (idx != LAST) begin
                nxt_idx = idx + 1'b1;
            end else if (mode_loop) begin
                nxt_idx = '0;
            end else begin
                nxt_state = IDLE;
                nxt_idx   = '0;
                nxt_done  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            dwell_l  <= '0;
            button_d <= 1'b0;
            ch_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            cnt      <= nxt_cnt;
            dwell_l  <= nxt_dwell;
            button_d <= button;
            ch_out   <= (nxt_state == RUN) ? NUM_CH'(1) << nxt_idx : '0;
            busy     <= (nxt_state == RUN);
            done     <= nxt_done;
        end
    end
endmodule
